// File: rtl/control_merge.sv
// Control merge: SIZE-way arbiter into a one-entry transparent slot feeding an eager data/index fork; 0-cycle latency when the slot is empty.
// Backpressure holds the token in the slot and drops every ins_ready; CMERGE_ROUND_ROBIN_EN swaps fixed priority for a rotating pointer.
module control_merge #(
  parameter int SIZE       = 2,
  parameter int DATA_TYPE  = 10,
  parameter int INDEX_TYPE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*DATA_TYPE-1:0] ins,
  input  logic [SIZE-1:0]           ins_valid,
  output logic [SIZE-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]      outs,
  output logic                      outs_valid,
  input  logic                      outs_ready,
  output logic [INDEX_TYPE-1:0]     index,
  output logic                      index_valid,
  input  logic                      index_ready
);

  logic                  win_vld;
  logic [INDEX_TYPE-1:0] win_idx;
  logic [DATA_TYPE-1:0]  win_dat;

  logic                  full_q, full_d;
  logic [DATA_TYPE-1:0]  dat_q, dat_d;
  logic [INDEX_TYPE-1:0] idx_q, idx_d;
  logic                  sent_out_q, sent_out_d;
  logic                  sent_idx_q, sent_idx_d;

  logic                  slot_vld;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  idx_xfer;
  logic                  fork_done;

`ifdef CMERGE_ROUND_ROBIN_EN
  logic [INDEX_TYPE-1:0] ptr_q, ptr_d;
  logic                  hi_vld, lo_vld;
  logic [INDEX_TYPE-1:0] hi_idx, lo_idx;

  // hi_* finds the first valid channel at or above the pointer; lo_* wraps around to the lowest.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int j = SIZE - 1; j >= 0; j--) begin
      if (ins_valid[j]) begin
        lo_vld = 1'b1;
        lo_idx = INDEX_TYPE'(j);
        if (j >= int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = INDEX_TYPE'(j);
        end
      end
    end
    win_vld = lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer) begin
      ptr_d = (win_idx == INDEX_TYPE'(SIZE - 1)) ? '0 : win_idx + INDEX_TYPE'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int j = SIZE - 1; j >= 0; j--) begin
      if (ins_valid[j]) begin
        win_vld = 1'b1;
        win_idx = INDEX_TYPE'(j);
      end
    end
  end
`endif

  always_comb begin
    win_dat = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (win_idx == INDEX_TYPE'(j)) begin
        win_dat = ins[j*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // An empty slot is transparent, so the winner reaches the fork in the same cycle.
  always_comb begin
    slot_vld    = !rst && (full_q || win_vld);
    outs        = full_q ? dat_q : win_dat;
    index       = full_q ? idx_q : win_idx;
    outs_valid  = slot_vld && !sent_out_q;
    index_valid = slot_vld && !sent_idx_q;
    out_xfer    = outs_valid && outs_ready;
    idx_xfer    = index_valid && index_ready;
    fork_done   = slot_vld && (sent_out_q || out_xfer) && (sent_idx_q || idx_xfer);
    in_xfer     = !rst && !full_q && win_vld;
    ins_ready   = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (in_xfer && (win_idx == INDEX_TYPE'(j))) begin
        ins_ready[j] = 1'b1;
      end
    end
  end

  always_comb begin
    full_d     = full_q;
    dat_d      = dat_q;
    idx_d      = idx_q;
    sent_out_d = sent_out_q;
    sent_idx_d = sent_idx_q;
    if (in_xfer && !fork_done) begin
      full_d = 1'b1;
      dat_d  = win_dat;
      idx_d  = win_idx;
    end else if (full_q && fork_done) begin
      full_d = 1'b0;
    end
    if (fork_done) begin
      sent_out_d = 1'b0;
      sent_idx_d = 1'b0;
    end else begin
      sent_out_d = sent_out_q || out_xfer;
      sent_idx_d = sent_idx_q || idx_xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 1'b0;
      sent_out_q <= 1'b0;
      sent_idx_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      sent_out_q <= sent_out_d;
      sent_idx_q <= sent_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    dat_q <= dat_d;
    idx_q <= idx_d;
  end

  assert property (@(posedge clk) disable iff (rst)
    (outs_valid && !outs_ready) |=> (outs_valid && $stable(outs)));
  assert property (@(posedge clk) disable iff (rst)
    (index_valid && !index_ready) |=> (index_valid && $stable(index)));
  assert property (@(posedge clk) $onehot0(ins_ready));

endmodule
